fir_decim_fifo: RTL and testbench

FIR_DECIM_FIFO -- requirements
Module: fir_decim_fifo

---
 rtl/fir_decim_fifo.sv | 105 ++++++++++
 tb/tb_fir_decim_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_fifo.sv
// Settle-gated decimator feeding a first-word-fall-through output FIFO.
// Ports: din/din_valid in, m_data/m_valid/m_ready out, settled, level, ovf/ovf_clr.
module fir_decim_fifo #(
  parameter int DATA_WIDTH = 16,
  parameter int DECIM      = 4,
  parameter int SETTLE     = 130,
  parameter int DEPTH      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     din_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic                     settled,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SETTLE + 2);
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [CW-1:0] SET_N  = CW'(SETTLE);
  localparam logic [PW-1:0] PH_MAX = PW'(DECIM - 1);
  localparam logic [AW:0]   FULL   = (AW + 1)'(DEPTH);

  logic [CW-1:0]         cnt;
  logic [PW-1:0]         phase;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic push;
  logic pop;
  logic full;
  logic wr_en;
  logic ovf_set;

  // Settle window; zero-length window still takes one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      settled <= 1'b0;
    end else if (!settled) begin
      if (SET_N == '0) begin
        settled <= 1'b1;
      end else if (din_valid) begin
        cnt <= cnt + 1'b1;
        if (cnt == SET_N - 1'b1)
          settled <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      phase <= '0;
    else if (din_valid && settled)
      phase <= (phase == PH_MAX) ? '0 : phase + 1'b1;
  end

  assign push    = din_valid && settled && (phase == '0);
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;
  assign full    = (level == FULL);
  // A full FIFO still takes a push when the head leaves this cycle.
  assign wr_en   = push && (!full || pop);
  assign ovf_set = push && full && !pop;
  assign m_data  = m_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr_en, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // A fresh overflow wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else
      ovf <= ovf_set || (ovf && !ovf_clr);
  end

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Scoreboard bench for fir_decim_fifo: sample-count model predicts pushes,
// a negedge monitor compares FIFO output and status against it.
module tb_fir_decim_fifo;

  localparam int DW     = 16;
  localparam int DECIM  = 4;
  localparam int SETTLE = 130;
  localparam int DEPTH  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic          settled;
  logic [3:0]    level;
  logic          ovf;
  logic          ovf_clr = 1'b0;

  int passed = 0;
  int total  = 0;

  int            n = 0;
  int            mlevel = 0;
  bit            exp_ovf = 0;
  logic [DW-1:0] sb [$];
  int            x;

  fir_decim_fifo #(
    .DATA_WIDTH(DW),
    .DECIM(DECIM),
    .SETTLE(SETTLE),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .din(din),
    .din_valid(din_valid),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .settled(settled),
    .level(level),
    .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp)
      passed++;
    else
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // Reference: the k-th accepted sample (0-based) is kept when
  // k >= SETTLE and (k - SETTLE) is a multiple of DECIM.
  always @(posedge clk or negedge rst_n) begin : model
    bit p_pop, p_push, p_drop;
    if (!rst_n) begin
      n = 0;
      mlevel = 0;
      exp_ovf = 0;
      sb.delete();
    end else begin
      p_pop  = (mlevel > 0) && m_ready;
      p_push = 0;
      p_drop = 0;
      if (din_valid) begin
        if (n >= SETTLE && ((n - SETTLE) % DECIM) == 0)
          p_push = 1;
        n++;
      end
      if (p_push) begin
        if (mlevel == DEPTH && !p_pop)
          p_drop = 1;
        else begin
          sb.push_back(din);
          mlevel++;
        end
      end
      if (p_pop)
        mlevel--;
      exp_ovf = p_drop || (exp_ovf && !ovf_clr);
    end
  end

  always @(negedge clk) begin : monitor
    chk("m_valid", 32'(m_valid), 32'(mlevel != 0));
    chk("level", 32'(level), 32'(mlevel));
    chk("settled", 32'(settled), 32'(n >= SETTLE));
    chk("ovf", 32'(ovf), 32'(exp_ovf));
    if (m_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_word", 32'(m_data), 32'hFFFF_FFFF);
      end else begin
        chk("m_data", 32'(m_data), 32'(sb[0]));
        if (m_ready)
          void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d,
                      input logic r, input logic c);
    @(posedge clk);
    #1;
    din_valid = v;
    din       = d;
    m_ready   = r;
    ovf_clr   = c;
  endtask

  task automatic ramp_settle(input int cnt);
    for (int i = 1; i <= cnt; i++) begin
      step(1'b1, DW'(i), 1'b1, 1'b0);
      if (i == SETTLE)
        chk("settle_before", 32'(settled), 32'd0);
      if (i == SETTLE + 1)
        chk("settle_rise", 32'(settled), 32'd1);
    end
    step(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic drain(input int cyc);
    for (int i = 0; i < cyc; i++)
      step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    int guard;
    int p;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_settled", 32'(settled), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // settle window on a ramp, then the ramp continues with gaps
    ramp_settle(SETTLE + 12);
    x = SETTLE + 13;
    for (int j = 0; j < 40; j++) begin
      if (j % 2 == 0) begin
        step(1'b1, DW'(x), 1'b1, 1'b0);
        x++;
      end else
        step(1'b0, DW'(9999), 1'b1, 1'b0);
    end

    // random traffic, backpressure and clears
    for (int j = 0; j < 300; j++)
      step(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0,
           ($urandom % 8) == 0);

    // backpressure: 10 pushes into an empty FIFO with no pops
    drain(12);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    for (int j = 0; j < 10 * DECIM; j++)
      step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("bp_level_full", 32'(level), 32'd8);
    chk("bp_ovf_set", 32'(ovf), 32'd1);
    drain(12);
    chk("bp_drained", 32'(level), 32'd0);
    chk("bp_ovf_sticky", 32'(ovf), 32'd1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_ovf_clr", 32'(ovf), 32'd0);

    // fill to DEPTH, then push and pop on the same edge
    guard = 0;
    while (mlevel < DEPTH && guard < 100) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0);
      guard++;
    end
    chk("fill_bound", 32'(guard < 100), 32'd1);
    for (int j = 0; j < DECIM - 2; j++)
      step(1'b1, DW'($urandom), 1'b0, 1'b0);
    step(1'b1, DW'(16'h1234), 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("fwp_level", 32'(level), 32'd8);
    chk("fwp_ovf", 32'(ovf), 32'd0);

    // overflow coinciding with a clear keeps ovf set
    for (int j = 0; j < DECIM; j++)
      step(1'b1, DW'($urandom), 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0);
    chk("ovf_clr_collide", 32'(ovf), 32'd1);
    drain(12);
    step(1'b0, '0, 1'b1, 1'b1);

    // reset with five words buffered
    guard = 0;
    while (mlevel < 5 && guard < 100) begin
      step(1'b1, DW'($urandom), 1'b0, 1'b0);
      guard++;
    end
    chk("fill5_bound", 32'(guard < 100), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(m_valid), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_settled", 32'(settled), 32'd0);
    step(1'b0, '0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 1'b0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b1, 1'b0);
    chk("post_rst_level", 32'(level), 32'd0);
    ramp_settle(SETTLE + 10);

    // signed extremes on phase-0 samples
    p = (n - SETTLE) % DECIM;
    for (int k = 0; k < 2 * DECIM + 1; k++) begin
      if (p == 0 && k < DECIM)
        step(1'b1, DW'(16'h8000), 1'b1, 1'b0);
      else if (p == 0)
        step(1'b1, DW'(16'h7FFF), 1'b1, 1'b0);
      else
        step(1'b1, DW'($urandom), 1'b1, 1'b0);
      p = (p + 1) % DECIM;
    end

    guard = 0;
    while ((sb.size() != 0 || mlevel != 0) && guard < 50) begin
      step(1'b0, '0, 1'b1, 1'b0);
      guard++;
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("final_drain", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
